pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry adder; next generation of the fixed 8-bit adder.
//   Splits a WIDTH-bit add into CHUNK-bit stages with registered carry between stages.
//   Gives a short critical path at any width, one result per clock, valid/ready flow control.
//   Sits in the MAC datapath between the multiplier output and the accumulator register.
// PARAMETERS
//   WIDTH   16  operand/sum width in bits; must be a multiple of CHUNK
//   CHUNK   4   bits added per pipeline stage; STAGES = WIDTH/CHUNK
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/carry_in valid this cycle
//   in_ready   out  1      pipeline accepts input this cycle
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   carry_in   in   1      carry into bit 0
//   out_valid  out  1      sum/carry_out valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  a + b + carry_in, modulo 2^WIDTH (see CONFIGURATION)
//   carry_out  out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   - Reset: all stage registers, valid bits, sum, carry_out and out_valid clear to 0 at once.
//     in_ready is 1 during reset and after release.
//   - Stage k (0..STAGES-1) adds chunk k of a/b with the carry registered from stage k-1.
//     Stage 0 uses carry_in.
//   - Operand bits above chunk k travel forward unchanged; lower sum chunks travel forward aligned.
//   - Latency: exactly STAGES cycles from accepted input (in_valid && in_ready at edge N)
//     to out_valid at edge N+STAGES, with no stalls. Throughput is 1 result/cycle.
//   - Stall: stall = out_valid && !out_ready.
//     While stalled, every stage register holds and in_ready = 0. Otherwise in_ready = 1.
//   - Bubbles (in_valid=0) propagate as invalid slots and are not compressed.
//   - A result is consumed on an edge with out_valid && out_ready.
//   - sum/carry_out stay stable while out_valid && !out_ready.
//   - Per-stage valid bit shifts with the data. out_valid is the last stage's valid bit.
//   - Simultaneous consume and accept: a new entry enters while the old result leaves. No loss.
//   - Arithmetic: each stage computes a (CHUNK+1)-bit sum.
//     The low CHUNK bits are the sum chunk and the MSB is the registered carry.
//     The final carry drives carry_out. There is no overflow wrap beyond WIDTH bits.
//   - rst_n asserted mid-operation: all in-flight entries are discarded and out_valid drops
//     immediately (async). No stale result appears after release.
//   - Data registers of invalid slots may hold any value. Only valid-qualified outputs are specified.
//   - Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.
// CONFIGURATION
//   ADDER_SAT_EN defined:
//     - when the final carry is 1, sum is forced to all-ones (unsigned saturation);
//     - carry_out still reports 1;
//     - latency is unchanged; the saturation mux sits in the last stage.
//   ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH; no saturation logic is built.
// TESTING  (WIDTH=16, CHUNK=4, latency 4)
//   1. Assert rst_n=0 mid-run
//      -> out_valid=0, sum=0x0000, carry_out=0 immediately; in_ready=1.
//   2. a=0x00FF, b=0x0001, carry_in=0, single beat
//      -> 4 cycles later out_valid=1, sum=0x0100, carry_out=0.
//   3. a=0xFFFF, b=0x0001, carry_in=0
//      -> sum=0x0000, carry_out=1; with ADDER_SAT_EN: sum=0xFFFF, carry_out=1.
//   4. a=0x7FFF, b=0x8000, carry_in=1
//      -> sum=0x0000, carry_out=1, testing carry ripple through all 4 stages.
//   5. 8 back-to-back beats, out_ready=0 for 3 cycles mid-stream
//      -> in_ready=0 during the stall, output held stable, all 8 results in order, none dropped.
//   6. Reset pulse with 3 beats in flight
//      -> none of them emerge after release; the next beat emerges 4 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
interface pipelined_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out
  );

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked ripple-carry adder pipeline with valid/ready stall
// Optional unsigned saturation on final carry: define ADDER_SAT_EN.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;

  generate
    if ((CHUNK < 1) || ((WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  // Slot 0 captures raw operands; slot k+1 holds the result of adding chunk k.
  logic [STAGES:0]  v_q, v_d;
  logic [STAGES:0]  c_q, c_d;
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [WIDTH-1:0] s_d [STAGES+1];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [CHUNK:0]   part;
  logic             stall;

  assign stall         = v_q[STAGES] && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = v_q[STAGES];
  assign bus.sum       = s_q[STAGES];
  assign bus.carry_out = c_q[STAGES];

  always_comb begin
    v_d     = {v_q[STAGES-1:0], bus.in_valid};
    c_d     = '0;
    c_d[0]  = bus.carry_in;
    s_d[0]  = '0;
    a_d[0]  = bus.a;
    b_d[0]  = bus.b;
    part    = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_q[k]};
      s_d[k+1]                    = s_q[k];
      s_d[k+1][k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
      c_d[k+1]                    = part[CHUNK];
    end
`ifdef ADDER_SAT_EN
    if (c_d[STAGES]) begin
      s_d[STAGES] = '1;
    end
`endif
  end

  // A stall freezes every slot so the held result and in-flight entries stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      s_q <= '{default: '0};
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else if (!stall) begin
      v_q <= v_d;
      c_q <= c_d;
      s_q <= s_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder (WIDTH=16, CHUNK=4)
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus ();

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  logic [16:0] exp_q [$];
  logic        obs_fire, obs_have, obs_valid, obs_in_ready, obs_accept, obs_co;
  logic [15:0] obs_sum;
  logic [16:0] obs_exp;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
`ifdef ADDER_SAT_EN
    if (r[16]) r[15:0] = 16'hFFFF;
`endif
    return r;
  endfunction

  // One cycle: drive at negedge, observe settled outputs, update scoreboard for the coming edge.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.carry_in  = ci;
    bus.out_ready = ordy;
    #1;
    obs_valid    = bus.out_valid;
    obs_in_ready = bus.in_ready;
    obs_sum      = bus.sum;
    obs_co       = bus.carry_out;
    obs_fire     = bus.out_valid && ordy;
    obs_accept   = v && bus.in_ready;
    obs_have     = 1'b0;
    obs_exp      = '0;
    if (obs_fire && exp_q.size() > 0) begin
      obs_exp  = exp_q.pop_front();
      obs_have = 1'b1;
    end
    if (obs_accept) exp_q.push_back(model(a, b, ci));
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL por_out_valid: got %b want 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL por_in_ready: got %b want 1", bus.in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      if (obs_fire) begin
        checks++;
        if (!obs_have || {obs_co, obs_sum} !== obs_exp)
          $display("FAIL reset_run_result: got %h want %h", {obs_co, obs_sum}, obs_exp);
        else passed++;
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", bus.out_valid);
    else passed++;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.sum !== 16'h0000) $display("FAIL midrst_sum: got %h want 0000", bus.sum);
    else passed++;
    checks++;
    if (bus.carry_out !== 1'b0) $display("FAIL midrst_carry: got %b want 0", bus.carry_out);
    else passed++;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);
    else passed++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [16:0] ve [3];
    int          lat, seen;
    va[0] = 16'h00FF; vb[0] = 16'h0001; vc[0] = 1'b0; ve[0] = 17'h00100;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0;
`ifdef ADDER_SAT_EN
    ve[1] = 17'h1FFFF;
`else
    ve[1] = 17'h10000;
`endif
    va[2] = 16'h7FFF; vb[2] = 16'h8000; vc[2] = 1'b1; ve[2] = 17'h10000;
    for (int v = 0; v < 3; v++) begin
      drive(1'b1, va[v], vb[v], vc[v], 1'b1);
      lat  = -1;
      seen = 0;
      for (int i = 1; i <= 10; i++) begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        if (obs_fire) begin
          seen++;
          if (lat < 0) lat = i - 1;
          checks++;
          if ({obs_co, obs_sum} !== ve[v])
            $display("FAIL vec%0d_result: got %h want %h", v, {obs_co, obs_sum}, ve[v]);
          else passed++;
        end
      end
      checks++;
      if (lat !== 4) $display("FAIL vec%0d_latency: got %0d want 4", v, lat);
      else passed++;
      checks++;
      if (seen !== 1) $display("FAIL vec%0d_count: got %0d want 1", v, seen);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int          idx, consumed, stall_seen, c;
    logic        stalling, ordy;
    logic [16:0] held;
    idx = 0; consumed = 0; stall_seen = 0; c = 0;
    stalling = 1'b0;
    held = '0;
    while (c < 40 && !(idx == 8 && consumed == 8)) begin
      ordy = !(c >= 6 && c <= 8);
      drive(idx < 8, 16'($urandom), 16'($urandom), 1'($urandom), ordy);
      if (obs_accept) idx++;
      if (obs_valid && !ordy) begin
        stall_seen++;
        checks++;
        if (obs_in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", obs_in_ready);
        else passed++;
        if (!stalling) begin
          held     = {obs_co, obs_sum};
          stalling = 1'b1;
        end else begin
          checks++;
          if ({obs_co, obs_sum} !== held)
            $display("FAIL stall_hold: got %h want %h", {obs_co, obs_sum}, held);
          else passed++;
        end
      end else begin
        stalling = 1'b0;
      end
      if (obs_fire) begin
        consumed++;
        checks++;
        if (!obs_have || {obs_co, obs_sum} !== obs_exp)
          $display("FAIL b2b_result: got %h want %h", {obs_co, obs_sum}, obs_exp);
        else passed++;
      end
      c++;
    end
    checks++;
    if (consumed !== 8) $display("FAIL b2b_count: got %0d want 8", consumed);
    else passed++;
    checks++;
    if (stall_seen !== 3) $display("FAIL b2b_stall_cycles: got %0d want 3", stall_seen);
    else passed++;
    checks++;
    if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_inflight;
    int fires, lat;
    for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (obs_valid) fires++;
    end
    checks++;
    if (fires !== 0) $display("FAIL inflight_stale: got %0d outputs want 0", fires);
    else passed++;
    drive(1'b1, 16'h1234, 16'h0F0F, 1'b1, 1'b1);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (obs_fire && lat < 0) begin
        lat = i - 1;
        checks++;
        if ({obs_co, obs_sum} !== 17'h02144)
          $display("FAIL inflight_next_result: got %h want 02144", {obs_co, obs_sum});
        else passed++;
      end
    end
    checks++;
    if (lat !== 4) $display("FAIL inflight_next_latency: got %0d want 4", lat);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
